auth_request_engine: RTL
========================

AUTH_REQUEST_ENGINE -- requirements
Module: auth_request_engine

Interface
REQ-001 The block SHALL have parameter NUM_SLOTS, default 4; number of certificate slots, range 1..8.
REQ-002 The block SHALL have parameter MAX_RETRIES, default 2; retransmissions allowed after a timeout, range 0..7.
REQ-003 The block SHALL have parameter TO_W, default 32; width of the timeout counter.
REQ-004 The block SHALL have parameters CHAL_TO, DIG_TO and CERT_TO; timeouts in cycles, defaulting to the package constants.
REQ-005 The block SHALL have these ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request offered.
- req_type  in  2  1=CHALLENGE, 2=DIGESTS, 3=CERTIFICATE, 0=invalid.
- req_slot  in  3  target slot.
- req_ready  out  1  engine can accept a request.
- msg_valid  out  1  message fields valid for transmit.
- msg_ready  in  1  transport accepts the message.
- header  out  32  {ProtocolVersion, MessageType, Param1, Param2}, 8 bits each, MSB first.
- bmRequestType  out  8  USB setup field.
- bRequest  out  8  USB setup field.
- wLength  out  16  USB setup field.
- current_timeout  out  TO_W  remaining cycles of the active timeout.
- resp_valid  in  1  responder reply arrived.
- resp_error  in  1  reply is an ERROR message; qualified by resp_valid.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on successful completion.
- fail  out  1  one-cycle pulse on failure.
- fail_code  out  2  0=none, 1=invalid request, 2=timeout, 3=responder error; held until the next accepted request.

Function
REQ-006 The state machine SHALL have exactly the states IDLE, CHECK, SEND, WAIT_RESP, RETRY and FINISH, one-hot encoded.
REQ-007 In IDLE, req_ready SHALL be 1; req_valid=1 SHALL capture req_type and req_slot, clear fail_code and go to CHECK on the next edge.
REQ-008 In CHECK, if req_type==0, or req_slot>=NUM_SLOTS for CHALLENGE or CERTIFICATE, the block SHALL go to FINISH with fail_code=1; otherwise it SHALL go to SEND.
REQ-009 On entry to SEND, the outputs SHALL be registered as follows, with ProtocolVersion=0x01 and Param2=0x00:
- CHALLENGE: MessageType 0x83, Param1 slot, bmRequestType 128, bRequest 24, wLength 168, timeout CHAL_TO.
- DIGESTS: MessageType 0x81, Param1 0, bmRequestType 128, bRequest 24, wLength 260, timeout DIG_TO.
- CERTIFICATE: MessageType 0x82, Param1 slot, bmRequestType 0, bRequest 25, wLength 2052, timeout CERT_TO.
REQ-010 msg_valid SHALL be 1 throughout SEND.
REQ-011 The header and setup fields SHALL stay stable while msg_valid=1 and msg_ready=0.
REQ-012 A cycle in SEND with msg_ready=1 SHALL complete the transfer, load current_timeout with the type's timeout, and go to WAIT_RESP.
REQ-013 In WAIT_RESP, current_timeout SHALL decrement by 1 per cycle and saturate at 0.
REQ-014 In WAIT_RESP, resp_valid=1 with resp_error=0 SHALL go to FINISH with done.
REQ-015 In WAIT_RESP, resp_valid=1 with resp_error=1 SHALL go to FINISH with fail_code=3.
REQ-016 When resp_valid=1 in the same cycle that current_timeout==1, the response SHALL take priority over the timeout.
REQ-017 When current_timeout reaches 0 with no response, the block SHALL go to RETRY.
REQ-018 RETRY SHALL increment the retry counter and return to SEND with identical fields if the count is at or below MAX_RETRIES; otherwise it SHALL go to FINISH with fail_code=2.
REQ-019 FINISH SHALL last exactly one cycle, pulse done or fail, and return to IDLE.
REQ-020 req_valid SHALL be ignored in every state except IDLE; the block has no request queueing.
REQ-021 resp_valid SHALL be ignored outside WAIT_RESP.
REQ-022 Outside WAIT_RESP, current_timeout SHALL hold its last value; it SHALL be 0 after reset.

Reset
REQ-023 While reset=1, the state SHALL be IDLE and the retry counter 0.
REQ-024 While reset=1, all outputs SHALL be 0, except req_ready, which SHALL be 1.
REQ-025 Reset asserted in any state, including mid-SEND or mid-WAIT_RESP, SHALL abort the transaction on the next edge with no done or fail pulse.

Structure
REQ-026 The shared package SHALL hold:
- the message-type codes 0x81, 0x82 and 0x83;
- the protocol version;
- the bmRequestType, bRequest and wLength values;
- the default timeouts CHALLENGE_TIMEOUT, DIGEST_REQ_TIMEOUT and GET_CERTIFICATE_TIMEOUT;
- the fail_code encodings;
- the state encoding.
REQ-027 The timeout down-counter SHALL be one sub-module, auth_timeout_counter, with load, enable, value and expired signals; everything else stays in the top module.

Verification
REQ-028 DIGESTS request, msg_ready held 1, resp_valid 5 cycles later -> header 0x01810000, wLength 260, done pulses once, fail_code 0.
REQ-029 CHALLENGE on slot 2, msg_ready held low for 3 cycles -> msg_valid and header 0x01830200 stable for all 4 cycles; one transfer only.
REQ-030 CERTIFICATE with CERT_TO=4 and no response, MAX_RETRIES=2 -> 3 SEND phases, then fail with fail_code 2, 3 transfers total.
REQ-031 CHALLENGE on slot 5 with NUM_SLOTS=4, and req_type 0 -> no msg_valid, fail with fail_code 1 within 3 cycles.
REQ-032 resp_valid in the same cycle that current_timeout==1 -> done, no RETRY; separately, resp_error=1 -> fail_code 3.
REQ-033 reset asserted during WAIT_RESP -> next cycle in IDLE, all outputs 0 except req_ready=1, no done or fail pulse.

Source files
------------

// File: rtl/auth_request_engine_pkg.sv
// auth_request_engine_pkg: shared constants, encodings and state type for the auth request engine
// Holds message-type codes, protocol version, USB setup values, default timeouts,
// request/fail encodings and the one-hot state encoding.
package auth_request_engine_pkg;

    localparam logic [7:0] PROTOCOL_VERSION    = 8'h01;

    localparam logic [7:0] MSG_GET_DIGESTS     = 8'h81;
    localparam logic [7:0] MSG_GET_CERTIFICATE = 8'h82;
    localparam logic [7:0] MSG_CHALLENGE       = 8'h83;

    localparam logic [7:0]  SETUP_IN_BM         = 8'd128;
    localparam logic [7:0]  SETUP_OUT_BM        = 8'd0;
    localparam logic [7:0]  SETUP_IN_BREQ       = 8'd24;
    localparam logic [7:0]  SETUP_OUT_BREQ      = 8'd25;
    localparam logic [15:0] CHALLENGE_WLENGTH   = 16'd168;
    localparam logic [15:0] DIGESTS_WLENGTH     = 16'd260;
    localparam logic [15:0] CERTIFICATE_WLENGTH = 16'd2052;

    localparam int unsigned CHALLENGE_TIMEOUT       = 64;
    localparam int unsigned DIGEST_REQ_TIMEOUT      = 32;
    localparam int unsigned GET_CERTIFICATE_TIMEOUT = 128;

    typedef enum logic [1:0] {
        REQ_INVALID     = 2'd0,
        REQ_CHALLENGE   = 2'd1,
        REQ_DIGESTS     = 2'd2,
        REQ_CERTIFICATE = 2'd3
    } req_type_e;

    typedef enum logic [1:0] {
        FAIL_NONE       = 2'd0,
        FAIL_INVALID    = 2'd1,
        FAIL_TIMEOUT    = 2'd2,
        FAIL_RESP_ERROR = 2'd3
    } fail_code_e;

    typedef enum logic [5:0] {
        IDLE      = 6'b000001,
        CHECK     = 6'b000010,
        SEND      = 6'b000100,
        WAIT_RESP = 6'b001000,
        RETRY     = 6'b010000,
        FINISH    = 6'b100000
    } state_e;

endpackage

// File: rtl/auth_request_engine_timeout_counter.sv
// auth_timeout_counter: loadable saturating down-counter for response timeouts
// Ports: clk, reset (sync, active-high), load/load_value (preset), enable (count down),
// value (remaining cycles), expired (value is at its last cycle or already 0).
module auth_timeout_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         enable,
    output logic [W-1:0] value,
    output logic         expired
);
    always_ff @(posedge clk)
        if (reset) value <= '0;
        else if (load) value <= load_value;
        else if (enable && value != '0) value <= value - 1'b1;
    // Asserted on the cycle whose decrement brings the count to zero.
    assign expired = value <= W'(1);
endmodule

// File: rtl/auth_request_engine.sv
// auth_request_engine: issues CHALLENGE/DIGESTS/CERTIFICATE requests with timeout and retry
// Ports: clk, reset (sync, active-high); req_valid/req_type/req_slot/req_ready request intake;
// msg_valid/msg_ready with header and USB setup fields (bmRequestType, bRequest, wLength);
// current_timeout; resp_valid/resp_error reply; busy, done/fail pulses, fail_code.
module auth_request_engine
    import auth_request_engine_pkg::*;
#(
    parameter int unsigned NUM_SLOTS   = 4,
    parameter int unsigned MAX_RETRIES = 2,
    parameter int unsigned TO_W        = 32,
    parameter int unsigned CHAL_TO     = CHALLENGE_TIMEOUT,
    parameter int unsigned DIG_TO      = DIGEST_REQ_TIMEOUT,
    parameter int unsigned CERT_TO     = GET_CERTIFICATE_TIMEOUT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    input  logic [1:0]      req_type,
    input  logic [2:0]      req_slot,
    output logic            req_ready,
    output logic            msg_valid,
    input  logic            msg_ready,
    output logic [31:0]     header,
    output logic [7:0]      bmRequestType,
    output logic [7:0]      bRequest,
    output logic [15:0]     wLength,
    output logic [TO_W-1:0] current_timeout,
    input  logic            resp_valid,
    input  logic            resp_error,
    output logic            busy,
    output logic            done,
    output logic            fail,
    output logic [1:0]      fail_code
);
    state_e          state;
    req_type_e       rtype;
    logic [2:0]      rslot;
    logic [3:0]      retries;
    logic [7:0]      msg_type, param1, bm_next, breq_next;
    logic [15:0]     wlen_next;
    logic [TO_W-1:0] to_load;
    logic            bad_req, expired;

    always_comb begin
        msg_type  = rtype == REQ_CHALLENGE ? MSG_CHALLENGE : rtype == REQ_DIGESTS ? MSG_GET_DIGESTS : MSG_GET_CERTIFICATE;
        param1    = rtype == REQ_DIGESTS ? 8'h00 : {5'd0, rslot};
        bm_next   = rtype == REQ_CERTIFICATE ? SETUP_OUT_BM : SETUP_IN_BM;
        breq_next = rtype == REQ_CERTIFICATE ? SETUP_OUT_BREQ : SETUP_IN_BREQ;
        wlen_next = rtype == REQ_CHALLENGE ? CHALLENGE_WLENGTH : rtype == REQ_DIGESTS ? DIGESTS_WLENGTH : CERTIFICATE_WLENGTH;
        to_load   = rtype == REQ_CHALLENGE ? TO_W'(CHAL_TO) : rtype == REQ_DIGESTS ? TO_W'(DIG_TO) : TO_W'(CERT_TO);
        // DIGESTS carries no slot, so only slot-addressed requests are range checked.
        bad_req   = rtype == REQ_INVALID || (rtype != REQ_DIGESTS && 32'(rslot) >= NUM_SLOTS);
    end

    auth_timeout_counter #(.W(TO_W)) u_timeout (
        .clk        (clk),
        .reset      (reset),
        .load       (state == SEND && msg_ready),
        .load_value (to_load),
        .enable     (state == WAIT_RESP),
        .value      (current_timeout),
        .expired    (expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            rtype         <= REQ_INVALID;
            rslot         <= '0;
            retries       <= '0;
            req_ready     <= 1'b1;
            msg_valid     <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            fail          <= 1'b0;
            fail_code     <= FAIL_NONE;
            header        <= '0;
            bmRequestType <= '0;
            bRequest      <= '0;
            wLength       <= '0;
        end else begin
            done <= 1'b0;
            fail <= 1'b0;
            case (state)
                IDLE: if (req_valid) begin
                    rtype     <= req_type_e'(req_type);
                    rslot     <= req_slot;
                    retries   <= '0;
                    fail_code <= FAIL_NONE;
                    req_ready <= 1'b0;
                    busy      <= 1'b1;
                    state     <= CHECK;
                end
                CHECK: if (bad_req) begin
                    fail      <= 1'b1;
                    fail_code <= FAIL_INVALID;
                    state     <= FINISH;
                end else begin
                    header        <= {PROTOCOL_VERSION, msg_type, param1, 8'h00};
                    bmRequestType <= bm_next;
                    bRequest      <= breq_next;
                    wLength       <= wlen_next;
                    msg_valid     <= 1'b1;
                    state         <= SEND;
                end
                SEND: if (msg_ready) begin
                    msg_valid <= 1'b0;
                    state     <= WAIT_RESP;
                end
                // A reply on the final count cycle wins over the timeout.
                WAIT_RESP: if (resp_valid) begin
                    done      <= !resp_error;
                    fail      <= resp_error;
                    fail_code <= resp_error ? FAIL_RESP_ERROR : FAIL_NONE;
                    state     <= FINISH;
                end else if (expired) begin
                    state <= RETRY;
                end
                // Fields are left untouched so a retransmission repeats the original message.
                RETRY: begin
                    retries <= retries + 1'b1;
                    if (32'(retries) < MAX_RETRIES) begin
                        msg_valid <= 1'b1;
                        state     <= SEND;
                    end else begin
                        fail      <= 1'b1;
                        fail_code <= FAIL_TIMEOUT;
                        state     <= FINISH;
                    end
                end
                FINISH: begin
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    msg_valid <= 1'b0;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule
